// File: rtl/dcache_dm_pkg.sv
// dcache_dm_pkg: shared encodings for the direct-mapped data cache
package dcache_dm_pkg;
  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam int LINE_WORDS = 4;
  typedef enum logic [1:0] {IDLE, REFILL, RESP, WRITE} state_t;
endpackage

// File: rtl/dcache_strb_gen.sv
// dcache_strb_gen: byte enables and lane-replicated store data from width and address
module dcache_strb_gen
  import dcache_dm_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wlane
);
  assign wstrb = width == MEM_B ? 4'b0001 << addr_lo : width == MEM_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wlane = width == MEM_B ? {4{wdata[7:0]}} : width == MEM_H ? {2{wdata[15:0]}} : wdata;
endmodule

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, blocking, write-through, no-write-allocate data cache
module dcache_dm
  import dcache_dm_pkg::*;
#(
  parameter int INDEX_W = 6,
  localparam int TAG_W = 32 - INDEX_W - 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mem_req_Dcache_i,
  input  logic        ex_mem_rw_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [1:0]  ex_mem_wrwidth_i,
  input  logic [31:0] ex_mem_wr_data_i,
  output logic        dc_rvalid_o,
  output logic [31:0] dc_rdata_o,
  output logic        dc_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int LINES = 1 << INDEX_W;
  state_t state, state_nx;
  logic s1_v, s1_rw;
  logic [31:0] s1_addr, s1_wdata, wlane;
  logic [1:0] s1_width, beat, off;
  logic [3:0] strb;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0] data [LINES][LINE_WORDS];
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic hit, last_beat;
  assign idx = s1_addr[INDEX_W+3:4];
  assign tag = s1_addr[31:INDEX_W+4];
  assign off = s1_addr[3:2];
  assign hit = valid[idx] && tags[idx] == tag;
  assign last_beat = beat == 2'(LINE_WORDS - 1);
  assign dc_rdata_o = dc_rvalid_o ? data[idx][off] : '0;
  dcache_strb_gen u_strb (
    .width(s1_width),
    .addr_lo(s1_addr[1:0]),
    .wdata(s1_wdata),
    .wstrb(strb),
    .wlane(wlane)
  );
  always_comb begin
    state_nx = state;
    dc_rvalid_o = 1'b0;
    dc_stall_o = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    mem_addr_o = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    case (state)
      IDLE: begin
        dc_rvalid_o = s1_v && !s1_rw && hit;
        dc_stall_o = s1_v && (s1_rw || !hit);
        if (dc_stall_o) state_nx = s1_rw ? WRITE : REFILL;
      end
      REFILL: begin
        mem_req_o = 1'b1;
        mem_addr_o = {tag, idx, beat, 2'b00};
        dc_stall_o = 1'b1;
        if (mem_ack_i && last_beat) state_nx = RESP;
      end
      RESP: begin
        dc_rvalid_o = 1'b1;
        state_nx = IDLE;
      end
      WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o = 1'b1;
        mem_addr_o = {s1_addr[31:2], 2'b00};
        mem_wdata_o = wlane;
        mem_wstrb_o = strb;
        dc_stall_o = !mem_ack_i;
        if (mem_ack_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat <= '0;
      valid <= '0;
      s1_v <= 1'b0;
      s1_rw <= 1'b0;
      s1_addr <= '0;
      s1_width <= '0;
      s1_wdata <= '0;
    end else begin
      state <= state_nx;
      if (!dc_stall_o) begin
        s1_v <= ex_mem_req_Dcache_i;
        s1_rw <= ex_mem_rw_i;
        s1_addr <= ex_mem_addr_i;
        s1_width <= ex_mem_wrwidth_i;
        s1_wdata <= ex_mem_wr_data_i;
      end
      if (state == REFILL && mem_ack_i) begin
        beat <= beat + 2'd1;
        if (last_beat) valid[idx] <= 1'b1;
      end
    end
  end
  // Tag and data storage carry no reset; validity alone gates visibility
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack_i) begin
      data[idx][beat] <= mem_rdata_i;
      if (last_beat) tags[idx] <= tag;
    end
    if (state == WRITE && mem_ack_i && hit)
      for (int b = 0; b < 4; b++)
        if (strb[b]) data[idx][off][8*b +: 8] <= wlane[8*b +: 8];
  end
endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: scoreboard bench with a line-level cache model and a word-addressed memory model
module tb_dcache_dm;
  import dcache_dm_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req = 1'b0, rw = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0] width = '0;
  logic rvalid, stall, mem_req, mem_we, mem_ack;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  typedef struct {logic we; logic [31:0] a; logic [3:0] strb; logic [31:0] d;} beat_t;
  typedef struct {logic [31:0] d; logic hit; int cyc;} ld_t;
  beat_t exp_beats[$];
  ld_t exp_loads[$];
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] line_of [int];
  int checks = 0, failures = 0, cyc = 0, fixed_dly = 2, beats_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_dm dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_req_Dcache_i(req), .ex_mem_rw_i(rw), .ex_mem_addr_i(addr),
    .ex_mem_wrwidth_i(width), .ex_mem_wr_data_i(wdata),
    .dc_rvalid_o(rvalid), .dc_rdata_o(rdata), .dc_stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] init_word(logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction
  function automatic logic [31:0] bus_rd(logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction
  function automatic logic [3:0] exp_strb(logic [1:0] w, logic [31:0] a);
    logic [1:0] lo = a[1:0];
    if (w == MEM_B) return 4'b0001 << lo;
    if (w == MEM_H) return lo[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction
  function automatic logic [31:0] exp_lane(logic [1:0] w, logic [31:0] a, logic [31:0] d);
    if (w == MEM_B) return {24'b0, d[7:0]} << (8 * a[1:0]);
    if (w == MEM_H) return {16'b0, d[15:0]} << (16 * a[1]);
    return d;
  endfunction
  function automatic logic [31:0] strb_mask(logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Record what a captured request must produce, then update the model
  task automatic model_issue(input logic r, input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    logic [31:0] base, wa, word, lane;
    logic [3:0] s;
    int i;
    logic h;
    base = {a[31:4], 4'h0};
    wa = {a[31:2], 2'b00};
    i = int'(a[9:4]);
    if (!r) begin
      h = line_of.exists(i) && line_of[i] == base;
      if (!h) begin
        for (int k = 0; k < 4; k++) exp_beats.push_back('{1'b0, base + 32'(4 * k), 4'h0, 32'h0});
        line_of[i] = base;
      end
      exp_loads.push_back('{ref_rd(wa), h, cyc + 1});
    end else begin
      s = exp_strb(w, a);
      lane = exp_lane(w, a, d);
      exp_beats.push_back('{1'b1, wa, s, lane});
      word = ref_rd(wa);
      word = (word & ~strb_mask(s)) | (lane & strb_mask(s));
      ref_mem[wa] = word;
    end
  endtask

  task automatic issue(input logic r, input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    int n;
    req = 1'b1; rw = r; addr = a; width = w; wdata = d;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!stall) break;
    end
    if (n == 300) begin
      checks++; failures++;
      $display("FAIL issue_timeout addr=%h stall stayed=1 required=0", a);
    end else model_issue(r, a, w, d);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_loads_empty();
    for (int n = 0; n < 300 && exp_loads.size() != 0; n++) @(negedge clk);
    chk("loads_drained", 32'(exp_loads.size()), 0);
    @(posedge clk); #1;
  endtask

  // Memory responder: acks after 0..3 idle cycles (or a fixed delay)
  initial begin
    int dly = -1;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!mem_req || mem_ack) dly = -1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (dly < 0) dly = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 3));
        if (dly == 0) begin
          mem_ack = 1'b1;
          mem_rdata = bus_rd(mem_addr);
        end else dly--;
      end
    end
  end

  // Bus monitor: every completed beat must match the next expected beat
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rst_n && mem_req && mem_ack) begin
      beats_done++;
      if (exp_beats.size() == 0) begin
        checks++; failures++;
        $display("FAIL beat_unexpected addr=%h we=%b required=no beat", mem_addr, mem_we);
      end else begin
        e = exp_beats.pop_front();
        chk("beat_we", 32'(mem_we), 32'(e.we));
        chk("beat_addr", mem_addr, e.a);
        if (e.we) begin
          chk("beat_strb", 32'(mem_wstrb), 32'(e.strb));
          chk("beat_wdata", mem_wdata & strb_mask(e.strb), e.d & strb_mask(e.strb));
        end
      end
      if (mem_we)
        bus_mem[mem_addr] = (bus_rd(mem_addr) & ~strb_mask(mem_wstrb)) | (mem_wdata & strb_mask(mem_wstrb));
    end
  end

  // Load monitor: every rvalid must match the next expected load
  initial forever begin
    ld_t e;
    @(negedge clk);
    if (rst_n && rvalid) begin
      if (exp_loads.size() == 0) begin
        checks++; failures++;
        $display("FAIL rvalid_unexpected rdata=%h required=no response", rdata);
      end else begin
        e = exp_loads.pop_front();
        chk("load_data", rdata, e.d);
        if (e.hit) chk("hit_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int b0, n;
    repeat (2) @(posedge clk); #1;
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
    chk("rst_rdata", rdata, 0);
    for (int k = 0; k < 4; k++) begin
      bus_mem[32'h1000 + 32'(4 * k)] = 32'h11 * (k + 1);
      ref_mem[32'h1000 + 32'(4 * k)] = 32'h11 * (k + 1);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 32'h0000_1004, MEM_W, 0);
    issue(0, 32'h0000_100C, MEM_W, 0);
    issue(1, 32'h0000_1005, MEM_B, 32'h0000_00AB);
    issue(0, 32'h0000_1004, MEM_W, 0);
    issue(1, 32'h0000_2000, MEM_W, 32'hDEAD_BEEF);
    issue(0, 32'h0000_2000, MEM_W, 0);
    issue(0, 32'h0000_1400, MEM_W, 0);
    issue(0, 32'h0000_1000, MEM_W, 0);
    wait_loads_empty();
    // Reset in the middle of a refill of a conflicting line
    req = 1'b1; rw = 1'b0; addr = 32'h0000_1800; width = MEM_W;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!stall) break;
    end
    for (int k = 0; k < 4; k++) exp_beats.push_back('{1'b0, 32'h1800 + 32'(4 * k), 4'h0, 32'h0});
    b0 = beats_done;
    @(posedge clk); #1;
    req = 1'b0;
    for (n = 0; n < 300 && beats_done < b0 + 2; n++) @(negedge clk);
    chk("beats_before_reset", 32'(beats_done - b0), 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 0);
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_rvalid", 32'(rvalid), 0);
    chk("midrst_mem_addr", mem_addr, 0);
    exp_beats.delete();
    line_of.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 32'h0000_1000, MEM_W, 0);
    fixed_dly = -1;
    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
      issue($urandom_range(0, 2) == 0, a, 2'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_loads_empty();
    for (n = 0; n < 50 && exp_beats.size() != 0; n++) @(negedge clk);
    chk("beats_drained", 32'(exp_beats.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
